// File: rtl/usb_token_tx_pkg.sv
// Shared SIE definitions: token FSM states, token PIDs and the CRC5 constants.
package usb_token_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_FIELD,
        ST_CRC,
        ST_EOP
    } tok_state_e;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_PING  = 4'b0100;

    localparam logic [4:0] CRC5_POLY = 5'b00101;
    localparam logic [4:0] CRC5_INIT = 5'b11111;

    function automatic logic pid_is_token(input logic [3:0] p);
        return (p == PID_OUT) || (p == PID_IN) || (p == PID_SOF) ||
               (p == PID_SETUP) || (p == PID_PING);
    endfunction

endpackage

// File: rtl/usb_token_tx_if.sv
// Token request and serial bit-stream signals; master = transmitter side.
interface usb_token_tx_if;
    logic        start;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [10:0] frame_num;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_ready;
    logic        busy;
    logic        eop;
    logic        pid_err;

    modport master (
        input  start, pid, addr, endp, frame_num, bit_ready,
        output bit_out, bit_valid, busy, eop, pid_err
    );

    modport slave (
        output start, pid, addr, endp, frame_num, bit_ready,
        input  bit_out, bit_valid, busy, eop, pid_err
    );
endinterface

// File: rtl/usb_token_tx_crc5_serial.sv
// Bit-serial CRC5 (x^5+x^2+1); exposes the raw register, inversion is left to the user.
module crc5_serial
    import usb_token_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       en,
    input  logic       din,
    output logic [4:0] crc
);
    logic fb;

    assign fb = crc[4] ^ din;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            crc <= CRC5_INIT;
        else if (init)
            crc <= CRC5_INIT;
        else if (en)
            crc <= {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
    end
endmodule

// File: rtl/usb_token_tx.sv
// USB token serializer: SYNC, PID, 11-bit field, CRC5, then one EOP cycle.
// Define USB_TOKEN_PID_CHECK_EN to reject non-token PIDs with a pid_err pulse.
module usb_token_tx
    import usb_token_tx_pkg::*;
#(
    parameter int SYNC_BITS = 8
) (
    input  logic           clk,
    input  logic           rst,
    usb_token_tx_if.master tok
);
    localparam logic [4:0] SYNC_LAST = 5'(SYNC_BITS - 1);

    tok_state_e  state, state_n;
    logic [4:0]  cnt, cnt_n;
    logic [3:0]  pid_q;
    logic [10:0] field_q;
    logic [4:0]  crc;
    logic        xfer, accept, reject, crc_en, bit_mux;

    assign xfer = tok.bit_valid && tok.bit_ready;

`ifdef USB_TOKEN_PID_CHECK_EN
    assign reject = (state == ST_IDLE) && tok.start && !pid_is_token(tok.pid);
`else
    assign reject = 1'b0;
`endif
    assign accept = (state == ST_IDLE) && tok.start && !reject;
    assign crc_en = (state == ST_FIELD) && xfer;

    crc5_serial u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (accept),
        .en   (crc_en),
        .din  (field_q[cnt[3:0]]),
        .crc  (crc)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_IDLE: if (accept) begin
                state_n = ST_SYNC;
                cnt_n   = 5'd0;
            end
            ST_SYNC: if (xfer) begin
                cnt_n = cnt + 5'd1;
                if (cnt == SYNC_LAST) begin
                    cnt_n   = 5'd0;
                    state_n = ST_PID;
                end
            end
            ST_PID: if (xfer) begin
                cnt_n = cnt + 5'd1;
                if (cnt == 5'd7) begin
                    cnt_n   = 5'd0;
                    state_n = ST_FIELD;
                end
            end
            ST_FIELD: if (xfer) begin
                cnt_n = cnt + 5'd1;
                if (cnt == 5'd10) begin
                    cnt_n   = 5'd0;
                    state_n = ST_CRC;
                end
            end
            ST_CRC: if (xfer) begin
                cnt_n = cnt + 5'd1;
                if (cnt == 5'd4) begin
                    cnt_n   = 5'd0;
                    state_n = ST_EOP;
                end
            end
            ST_EOP:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // bit_out decodes flopped state only, so it moves just after a transfer or state entry
    always_comb begin
        bit_mux = 1'b0;
        case (state)
            ST_SYNC:  bit_mux = (cnt == SYNC_LAST);
            ST_PID:   bit_mux = pid_q[cnt[1:0]] ^ cnt[2];
            ST_FIELD: bit_mux = field_q[cnt[3:0]];
            ST_CRC:   bit_mux = ~crc[3'd4 - cnt[2:0]];
            default:  bit_mux = 1'b0;
        endcase
    end

    assign tok.bit_out = bit_mux;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            cnt           <= 5'd0;
            pid_q         <= 4'd0;
            field_q       <= 11'd0;
            tok.bit_valid <= 1'b0;
            tok.busy      <= 1'b0;
            tok.eop       <= 1'b0;
            tok.pid_err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                pid_q   <= tok.pid;
                field_q <= (tok.pid == PID_SOF) ? tok.frame_num : {tok.endp, tok.addr};
            end
            tok.bit_valid <= (state_n == ST_SYNC) || (state_n == ST_PID) ||
                             (state_n == ST_FIELD) || (state_n == ST_CRC);
            tok.busy      <= (state_n != ST_IDLE);
            tok.eop       <= (state_n == ST_EOP);
            tok.pid_err   <= reject;
        end
    end
endmodule

// File: tb/tb_usb_token_tx.sv
// Randomized self-checking bench for usb_token_tx against a division-based token model.
module tb_usb_token_tx;
    import usb_token_tx_pkg::*;

    localparam int SB = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    usb_token_tx_if tok_if();

    usb_token_tx #(.SYNC_BITS(SB)) dut (
        .clk (clk),
        .rst (rst),
        .tok (tok_if)
    );

    int   checks = 0;
    int   errors = 0;
    int   eop_cnt = 0;
    bit   exp_q[$];
    bit   got_q[$];
    bit   rnd_mode = 1'b0;
    bit   prev_stall = 1'b0;
    logic prev_bit = 1'b0;

    always @(posedge clk) begin
        #1;
        tok_if.bit_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Collects transferred bits, counts eop pulses, checks hold during stalls
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (tok_if.bit_valid !== 1'b1 || tok_if.bit_out !== prev_bit) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b bit=%b, required valid=1 bit=%b",
                             tok_if.bit_valid, tok_if.bit_out, prev_bit);
                end
            end
            if (tok_if.bit_valid === 1'b1 && tok_if.bit_ready === 1'b1)
                got_q.push_back(tok_if.bit_out);
            if (tok_if.eop === 1'b1) eop_cnt++;
            prev_stall = (tok_if.bit_valid === 1'b1) && (tok_if.bit_ready !== 1'b1);
            prev_bit   = tok_if.bit_out;
        end
    end

    // Expected wire bits; CRC5 as polynomial remainder with the all-ones preset
    // folded into the first five message bits.
    function automatic void build_exp(input logic [3:0] p, input logic [10:0] fld);
        bit m[16];
        int rem;
        exp_q.delete();
        for (int i = 0; i < SB - 1; i++) exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        for (int i = 0; i < 4; i++) exp_q.push_back(p[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(~p[i]);
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back(fld[i]);
            m[i] = fld[i] ^ (i < 5);
        end
        for (int i = 11; i < 16; i++) m[i] = 1'b0;
        rem = 0;
        for (int i = 0; i < 16; i++) begin
            rem = (rem << 1) | int'(m[i]);
            if ((rem & 32) != 0) rem = rem ^ 37;
        end
        for (int i = 4; i >= 0; i--) exp_q.push_back(~rem[i]);
    endfunction

    task automatic run_token(input string name, input logic [3:0] p, input logic [6:0] a,
                             input logic [3:0] e, input logic [10:0] f, input bit rnd,
                             input int poke_cyc, input int rst_cyc, output int cyc);
        int e0;
        int bad;
        bit done;
        build_exp(p, (p == PID_SOF) ? f : {e, a});
        rnd_mode = rnd;
        got_q.delete();
        e0 = eop_cnt;
        tok_if.pid = p; tok_if.addr = a; tok_if.endp = e; tok_if.frame_num = f;
        tok_if.start = 1'b1;
        @(posedge clk); #1;
        tok_if.start = 1'b0;
        tok_if.pid = 4'($urandom); tok_if.addr = 7'($urandom); tok_if.endp = 4'($urandom);
        tok_if.frame_num = 11'($urandom);
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                checks++;
                if ({tok_if.bit_valid, tok_if.busy} !== 2'b11) begin
                    errors++;
                    $display("FAIL %s first_cycle: valid,busy=%b, required 11", name,
                             {tok_if.bit_valid, tok_if.busy});
                end
            end
            if (cyc == poke_cyc) begin
                checks++;
                if (tok_if.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_mid: busy=%b, required 1", name, tok_if.busy);
                end
                tok_if.start = 1'b1; tok_if.pid = PID_OUT; tok_if.addr = 7'($urandom);
            end
            if (cyc == poke_cyc + 1) tok_if.start = 1'b0;
            if (cyc == rst_cyc) begin
                rst = 1'b0;
                #1;
                checks++;
                if ({tok_if.bit_out, tok_if.bit_valid, tok_if.busy, tok_if.eop, tok_if.pid_err} !== 5'b0) begin
                    errors++;
                    $display("FAIL %s async_rst: outs=%b, required 00000", name,
                             {tok_if.bit_out, tok_if.bit_valid, tok_if.busy, tok_if.eop, tok_if.pid_err});
                end
                @(negedge clk);
                rst = 1'b1;
                repeat (4) @(negedge clk);
                checks++;
                if (eop_cnt != e0 || tok_if.bit_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s no_eop_after_rst: eops=%0d valid=%b, required 0 0", name,
                             eop_cnt - e0, tok_if.bit_valid);
                end
                rnd_mode = 1'b0;
                return;
            end
            if (tok_if.eop === 1'b1) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s eop_timeout: no eop in %0d cycles", name, cyc);
            rnd_mode = 1'b0;
            return;
        end
        if (!rnd) begin
            checks++;
            if (cyc != SB + 25) begin
                errors++;
                $display("FAIL %s eop_cycle: got %0d, required %0d", name, cyc, SB + 25);
            end
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s bit_count: got %0d, required %0d", name, got_q.size(), exp_q.size());
        end else begin
            bad = -1;
            for (int i = 0; i < exp_q.size(); i++)
                if (bad < 0 && got_q[i] != exp_q[i]) bad = i;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL %s bits: index %0d got %b, required %b", name, bad,
                         got_q[bad], exp_q[bad]);
            end
        end
        @(negedge clk);
        checks++;
        if ({tok_if.eop, tok_if.busy, tok_if.bit_valid} !== 3'b000 || eop_cnt - e0 != 1) begin
            errors++;
            $display("FAIL %s eop_once: eop,busy,valid=%b eops=%0d, required 000 1", name,
                     {tok_if.eop, tok_if.busy, tok_if.bit_valid}, eop_cnt - e0);
        end
        rnd_mode = 1'b0;
    endtask

    task automatic test_reset();
        tok_if.start = 1'b0; tok_if.pid = 4'd0; tok_if.addr = 7'd0; tok_if.endp = 4'd0;
        tok_if.frame_num = 11'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tok_if.bit_out, tok_if.bit_valid, tok_if.busy, tok_if.eop, tok_if.pid_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_vals: outs=%b, required 00000",
                     {tok_if.bit_out, tok_if.bit_valid, tok_if.busy, tok_if.eop, tok_if.pid_err});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({tok_if.bit_valid, tok_if.busy, tok_if.eop} !== 3'b0) begin
            errors++;
            $display("FAIL idle_after_reset: valid,busy,eop=%b, required 000",
                     {tok_if.bit_valid, tok_if.busy, tok_if.eop});
        end
    endtask

    task automatic test_setup();
        int c;
        logic [31:0] w;
        run_token("setup", PID_SETUP, 7'd0, 4'd0, 11'd0, 1'b0, -1, -1, c);
        w = '0;
        for (int i = 0; i < 32 && i < got_q.size(); i++) w[i] = got_q[i];
        checks++;
        if (w !== 32'h10002D80) begin
            errors++;
            $display("FAIL setup_bytes: got %h, required 10002d80 (80 2D 00 10)", w);
        end
    endtask

    task automatic test_sof_back_to_back();
        int c;
        run_token("sof_7ff", PID_SOF, 7'($urandom), 4'($urandom), 11'h7FF, 1'b0, -1, -1, c);
        run_token("sof_000", PID_SOF, 7'($urandom), 4'($urandom), 11'h000, 1'b0, -1, -1, c);
    endtask

    task automatic test_random_ready();
        int c;
        bit ref_q[$];
        int bad;
        run_token("in_ready1", PID_IN, 7'h15, 4'hE, 11'd0, 1'b0, -1, -1, c);
        ref_q = got_q;
        run_token("in_randready", PID_IN, 7'h15, 4'hE, 11'd0, 1'b1, -1, -1, c);
        bad = (ref_q.size() != got_q.size()) ? 0 : -1;
        for (int i = 0; i < ref_q.size() && bad < 0; i++)
            if (ref_q[i] != got_q[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL stall_vs_ready1: differs at %0d (sizes %0d/%0d)", bad,
                     got_q.size(), ref_q.size());
        end
    endtask

    task automatic test_random_tokens();
        logic [3:0] pids[5] = '{PID_OUT, PID_IN, PID_SOF, PID_SETUP, PID_PING};
        int c;
        for (int k = 0; k < 5; k++)
            run_token("rand_tok", pids[$urandom_range(0, 4)], 7'($urandom), 4'($urandom),
                      11'($urandom), 1'($urandom_range(0, 1)), -1, -1, c);
    endtask

    task automatic test_start_mid_field();
        int c;
        run_token("start_mid_field", PID_OUT, 7'h2A, 4'h3, 11'd0, 1'b0, SB + 12, -1, c);
    endtask

    task automatic test_rst_in_crc();
        int c;
        run_token("rst_in_crc", PID_SETUP, 7'h11, 4'h5, 11'd0, 1'b0, -1, SB + 22, c);
        run_token("after_rst", PID_SETUP, 7'h11, 4'h5, 11'd0, 1'b0, -1, -1, c);
    endtask

    task automatic test_pid_check();
`ifdef USB_TOKEN_PID_CHECK_EN
        bit seen_valid;
        int errs_seen;
        tok_if.pid = 4'b0011;
        tok_if.start = 1'b1;
        @(posedge clk); #1;
        tok_if.start = 1'b0;
        @(negedge clk);
        checks++;
        if ({tok_if.pid_err, tok_if.busy, tok_if.bit_valid} !== 3'b100) begin
            errors++;
            $display("FAIL pid_reject: pid_err,busy,valid=%b, required 100",
                     {tok_if.pid_err, tok_if.busy, tok_if.bit_valid});
        end
        seen_valid = 1'b0;
        errs_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (tok_if.bit_valid === 1'b1) seen_valid = 1'b1;
            if (tok_if.pid_err === 1'b1) errs_seen++;
        end
        checks++;
        if (seen_valid || errs_seen != 0) begin
            errors++;
            $display("FAIL pid_reject_quiet: valid_seen=%b extra_pid_err=%0d, required 0 0",
                     seen_valid, errs_seen);
        end
`else
        int c;
        run_token("pid_0011", 4'b0011, 7'h7F, 4'hF, 11'd0, 1'b0, -1, -1, c);
        checks++;
        if (tok_if.pid_err !== 1'b0) begin
            errors++;
            $display("FAIL pid_err_tied: got %b, required 0", tok_if.pid_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_setup();
        test_sof_back_to_back();
        test_random_ready();
        test_random_tokens();
        test_start_mid_field();
        test_rst_in_crc();
        test_pid_check();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/usb_token_tx.md
# usb_token_tx

Serial transmitter for USB token packets (OUT, IN, SETUP, PING, SOF). Latches the PID and the 11-bit token field, then emits SYNC, PID, field and CRC5 as an LSB-first bit stream. The CRC5 is computed on the fly. Sits upstream of the bit-stuff/NRZI stage in the Serial Interface Engine and feeds it through a valid/ready bit handshake.

## Interface
- SYNC_BITS, 8: length of the SYNC pattern in bits. It is SYNC_BITS-1 zeros followed by a single one. Legal values are 8 and 32.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request to send one token. Sampled only in IDLE.
- pid  in  4  token PID. The PID byte on the wire is {~pid, pid}.
- addr  in  7  device address (non-SOF tokens).
- endp  in  4  endpoint number (non-SOF tokens).
- frame_num  in  11  frame number, used when pid == 4'b0101 (SOF).
- bit_out  out  1  current serial bit.
- bit_valid  out  1  bit_out is valid.
- bit_ready  in  1  downstream accepts a bit. A transfer happens only when bit_valid && bit_ready.
- busy  out  1  high from the cycle after start is accepted until the EOP cycle, inclusive.
- eop  out  1  one-cycle pulse after the last CRC bit transfers. Tells downstream to drive SE0.
- pid_err  out  1  one-cycle pulse (present only with the configuration macro; see Configuration).

## Operation
- FSM states: IDLE, SYNC, PID, FIELD, CRC, EOP. A single 5-bit bit counter (cnt) drives the sequencing.
- IDLE: when start=1, latch the following on the same edge and go to SYNC with cnt=0:
  - pid;
  - field = (pid==4'b0101) ? frame_num : {endp, addr}, with addr in bits [6:0];
  - CRC register preset to 5'b11111.
- Each state advances cnt only on a transfer.
- SYNC: bit_out = (cnt==SYNC_BITS-1). After the last SYNC bit transfers, go to PID.
- PID: 8 bits, LSB first: pid[0..3], then ~pid[0..3].
- FIELD: 11 bits, field[0] first. Every transferred field bit is also clocked into the CRC. Generator polynomial is x^5+x^2+1, with feedback = crc[4]^bit.
- CRC: 5 bits from C = ~crc, sent C[4] first. The CRC register does not change during this state.
- EOP: bit_valid=0 and eop=1 for exactly one cycle, then return to IDLE.
- Inputs (pid, addr, endp, frame_num) are don't-care outside the start cycle.
- start while busy is ignored; no queuing.
- Async reset at any point, including mid-packet, forces IDLE immediately. The partial packet is abandoned and eop is not issued.

## Timing
- Reset values: bit_out=0, bit_valid=0, busy=0, eop=0, pid_err=0.
- Outputs are registered. bit_valid rises on the first clock after start is accepted.
- bit_out changes only after a transfer or on a state entry. It is held stable while bit_valid && !bit_ready.
- With bit_ready held at 1: one bit per cycle, SYNC_BITS+24 bit cycles, then the eop cycle. For SYNC_BITS=8 that is 33 cycles from the start edge to the end of eop.
- The cycle after eop is IDLE, so a new start can be accepted there. Back-to-back tokens therefore leave exactly one EOP cycle between them.
- bit_ready may toggle arbitrarily. The bit count per state and the CRC are unaffected by stalls.

## Configuration
- USB_TOKEN_PID_CHECK_EN defined:
  - In IDLE, start with a pid outside {0001, 1001, 0101, 1101, 0100} is rejected.
  - The FSM stays in IDLE and busy stays 0.
  - pid_err pulses for one cycle on the edge following the start.
- Undefined: any pid is serialized as given, and pid_err is tied to 0.

## Structure
- Shared SIE package holds:
  - state enum;
  - token PID constants PID_OUT/IN/SOF/SETUP/PING;
  - CRC5_POLY (5'b00101) and CRC5_INIT (5'b11111).
- Sub-module crc5_serial has ports:
  - clk, rst;
  - init (preset to INIT);
  - en (shift one bit);
  - din;
  - crc[4:0] (raw register; the inversion is done in the parent).
- The FSM, counter and output mux stay in usb_token_tx.

## Test plan
- SETUP, addr=0, endp=0, bit_ready=1:
  - Expected stream: 0000000_1, then 10110100, then 00000000000, then C[4..0] = 0,1,0,0,0.
  - Packed into bytes this is 0x80 0x2D 0x00 0x10.
  - eop is seen at cycle 33.
- SOF with frame_num=11'h7FF, then 11'h000 back-to-back:
  - Field bits match frame_num.
  - CRC matches the software model.
  - Exactly one eop cycle separates the two packets.
- Random bit_ready (50% duty) with IN, addr=7'h15, endp=4'hE:
  - Reassembled bits are identical to the ready=1 run.
  - bit_out is held stable whenever the handshake stalls.
- start asserted again mid-FIELD: it is ignored, the first packet completes unchanged, and busy stays 1.
- rst pulsed low during CRC:
  - All outputs go to their reset values immediately and no eop appears.
  - The next start sends a full, correct packet.
- With USB_TOKEN_PID_CHECK_EN, pid=4'b0011: pid_err pulses once, busy=0, bit_valid never rises. Without the macro, the same pid is serialized.
